// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid/enable sequencer for a STAGES-deep decode pipe with hold and flush recovery.
// Defining PIPE_CTRL_PERF_EN builds the saturating stall_cycles counter; otherwise it reads 0.
module pipe_stage_ctrl #(
   parameter int STAGES       = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         hold,
   input  logic                         flush,
   output logic [STAGES-1:0]            stage_en,
   output logic [STAGES-1:0]            stage_valid,
   output logic                         pipe_clr,
   output logic [$clog2(STAGES+1)-1:0]  occupancy,
   output logic [CNT_W-1:0]             stall_cycles
);
   localparam int OW = $clog2(STAGES+1);
   localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
   typedef enum logic {RUN, FLUSH} state_t;
   state_t            state_q;
   logic [FW-1:0]     fcnt_q;
   logic [STAGES-1:0] v_q, v_d, chain;
   logic              act, c;
   // A stage may advance when it or any stage downstream of it has room.
   always_comb begin
      act = (state_q == RUN) & ~hold & ~flush;
      c = out_ready;
      chain = '0;
      for (int i = STAGES-1; i >= 0; i--) begin
         c = c | ~v_q[i];
         chain[i] = c;
      end
      stage_en = act ? chain : '0;
      v_d[0] = stage_en[0] ? in_valid : v_q[0];
      for (int i = 1; i < STAGES; i++) v_d[i] = stage_en[i] ? v_q[i-1] : v_q[i];
      occupancy = '0;
      for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(v_q[i]);
   end
   assign in_ready    = stage_en[0];
   assign out_valid   = act & v_q[STAGES-1];
   assign pipe_clr    = (state_q == FLUSH);
   assign stage_valid = v_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         fcnt_q  <= '0;
         v_q     <= '0;
      end else if (state_q == FLUSH) begin
         if (fcnt_q == '0) state_q <= RUN;
         else fcnt_q <= fcnt_q - 1'b1;
      end else begin
         v_q <= flush ? '0 : v_d;
         if (flush) begin
            state_q <= FLUSH;
            fcnt_q  <= FW'(FLUSH_CYCLES-1);
         end
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else if ((state_q == RUN) & ~hold & v_q[STAGES-1] & ~out_ready & ~&stall_q) stall_q <= stall_q + 1'b1;
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif
endmodule
